oam_dma_bus: RTL and testbench
==============================

Name: oam_dma_bus

Overview:
- Sits directly downstream of the 6502 core, between the CPU bus (A/D/R/W/I, ce) and the system memory/PPU bus.
- Generates the CPU clock-enable tick from the 25 MHz clock and passes the CPU bus through to the system bus.
- Implements Dendy sprite DMA: a CPU write to $4014 stalls the CPU (ce held low) and copies page $XX00–$XXFF to the PPU OAM data port $2004.

Parameters:
- DIV, 14, system clocks per CPU tick (≥2); tick when divider = DIV-1.
- DMA_ADDR, 16'h4014, trigger address.
- OAM_PORT, 16'h2004, DMA write-target address.

Ports:
- clock  in  1  system clock, 25 MHz
- reset_n  in  1  reset, synchronous, active-low
- cpu_a  in  16  CPU address
- cpu_d  in  8  CPU write data
- cpu_r  in  1  CPU read strobe
- cpu_w  in  1  CPU write strobe
- cpu_i  out  8  data to CPU (= bus_i)
- cpu_ce  out  1  CPU clock enable
- bus_a  out  16  system bus address
- bus_o  out  8  system bus write data
- bus_r  out  1  system bus read
- bus_w  out  1  system bus write
- bus_i  in  8  system bus read data (valid before next tick)
- dma_busy  out  1  high while the DMA FSM is not IDLE

Behaviour:
- Reset (sync, reset_n=0 at posedge clock): div=0, cyc=0, state=IDLE, page=0, idx=0, latch=0.
  - cpu_ce=0, dma_busy=0.
  - Bus outputs follow the CPU passthrough.
  - Reset mid-DMA aborts the transfer; no further bus_w to OAM_PORT.
- Divider: div counts 0..DIV-1 and wraps. tick = (div==DIV-1), combinational.
  - cyc toggles on every tick. It is the CPU-cycle parity; it runs even while the CPU is stalled.
- cpu_ce = tick & (state==IDLE). It is combinational from registers.
  - The trigger tick still enables the CPU.
  - The tick that leaves the last WRITE does not enable the CPU; the CPU resumes on the following tick.
- Passthrough (state==IDLE): bus_a=cpu_a, bus_o=cpu_d, bus_r=cpu_r, bus_w=cpu_w. cpu_i=bus_i in all states.
- FSM: states advance only on tick.
  - IDLE: if cpu_w & cpu_a==DMA_ADDR: page<=cpu_d, idx<=0, go to HALT. The CPU write is also passed to the bus.
  - HALT: dummy cycle. Bus outputs: bus_a=cpu_a, bus_r=0, bus_w=0. Next state is ALIGN if cyc==1 at this tick, else READ.
  - ALIGN: dummy cycle, same bus outputs as HALT. Next state is READ.
  - READ: bus_a={page,idx}, bus_r=1, bus_w=0 for the whole interval. On tick: latch<=bus_i, go to WRITE.
  - WRITE: bus_a=OAM_PORT, bus_o=latch, bus_w=1, bus_r=0 for the whole interval. On tick: if idx==8'hFF go to IDLE, else idx<=idx+1 and go to READ.
- idx is 8-bit; the page never changes during a transfer and there is no carry into page.
- Stall length, counted in ticks with state≠IDLE: 513 when the trigger lands so that HALT sees cyc==0, 514 otherwise.
- dma_busy = (state≠IDLE).
- CPU strobes are ignored while busy. A new $4014 write is impossible while busy, because the CPU is frozen.
- Page $FF is legal and reads $FF00–$FFFF.

Test Plan:
- Divider: release reset with DIV=14 -> first cpu_ce at clock 14 after release, then every 14 clocks; one clock wide each.
- Passthrough: CPU reads $8000 with bus_i=8'h5A -> bus_a=16'h8000, bus_r=1, cpu_i=8'h5A; CPU writes $0300←8'h77 -> bus_w=1, bus_o=8'h77.
- Even-aligned DMA: write 8'h02 to $4014 with memory $0200+k = k^8'hA5 -> 256 writes to $2004 with data k^8'hA5 in order; 513 ticks with cpu_ce suppressed; dma_busy deasserts at the end.
- Odd-aligned DMA: same write issued one tick later (cyc==1 at HALT) -> exactly 514 stalled ticks; write data identical.
- Reset mid-DMA: assert reset_n=0 after the 100th OAM write -> next clock state IDLE, dma_busy=0, bus_w=0; no further $2004 writes.
- Boundary: DMA from page 8'hFF -> reads $FF00..$FFFF, last write idx 255, no access to $0000.

Source files
------------

// File: rtl/oam_dma_bus.sv
// CPU bus bridge for the 6502 core: derives the CPU clock enable from the system clock,
// passes CPU cycles to the system bus and runs Dendy sprite DMA into the PPU OAM port.
module oam_dma_bus #(
  parameter int          DIV      = 14,
  parameter logic [15:0] DMA_ADDR = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_r,
  input  logic        cpu_w,
  output logic [7:0]  cpu_i,
  output logic        cpu_ce,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_o,
  output logic        bus_r,
  output logic        bus_w,
  input  logic [7:0]  bus_i,
  output logic        dma_busy
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  logic [DW-1:0] div_q, div_d;
  logic          cyc_q, cyc_d;
  logic [2:0]    state_q, state_d;
  logic [7:0]    page_q, page_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    latch_q, latch_d;
  logic          tick;

  assign tick     = (div_q == DIV_LAST);
  assign cpu_ce   = tick && (state_q == IDLE);
  assign dma_busy = (state_q != IDLE);
  assign cpu_i    = bus_i;

  // cyc is CPU-cycle parity; it keeps running while the CPU is stalled so the
  // HALT decision knows whether an extra alignment cycle is needed.
  always_comb begin
    div_d   = tick ? '0 : div_q + DW'(1);
    cyc_d   = tick ? ~cyc_q : cyc_q;
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (cpu_w && (cpu_a == DMA_ADDR)) begin
            page_d  = cpu_d;
            idx_d   = 8'h00;
            state_d = HALT;
          end
        end
        HALT:  state_d = cyc_q ? ALIGN : READ;
        ALIGN: state_d = READ;
        READ: begin
          latch_d = bus_i;
          state_d = WRITE;
        end
        WRITE: begin
          if (idx_q == 8'hFF) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 8'h01;
            state_d = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_q   <= '0;
      cyc_q   <= 1'b0;
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      div_q   <= div_d;
      cyc_q   <= cyc_d;
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
    end
  end

  // Dummy cycles keep the CPU address on the bus but suppress both strobes.
  always_comb begin
    bus_a = cpu_a;
    bus_o = cpu_d;
    bus_r = cpu_r;
    bus_w = cpu_w;
    case (state_q)
      IDLE: ;
      READ: begin
        bus_a = {page_q, idx_q};
        bus_r = 1'b1;
        bus_w = 1'b0;
      end
      WRITE: begin
        bus_a = OAM_PORT;
        bus_o = latch_q;
        bus_r = 1'b0;
        bus_w = 1'b1;
      end
      default: begin
        bus_r = 1'b0;
        bus_w = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_bus.sv
// Directed bench for oam_dma_bus: divider timing, passthrough, even/odd aligned DMA,
// reset during DMA and the page $FF boundary, against a byte-array memory model.
module tb_oam_dma_bus;

  localparam int DIV = 14;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_r;
  logic        cpu_w;
  logic [7:0]  cpu_i;
  logic        cpu_ce;
  logic [15:0] bus_a;
  logic [7:0]  bus_o;
  logic        bus_r;
  logic        bus_w;
  logic [7:0]  bus_i;
  logic        dma_busy;

  int checks = 0;
  int errors = 0;

  oam_dma_bus #(.DIV(DIV)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w),
    .cpu_i(cpu_i), .cpu_ce(cpu_ce),
    .bus_a(bus_a), .bus_o(bus_o), .bus_r(bus_r), .bus_w(bus_w),
    .bus_i(bus_i), .dma_busy(dma_busy)
  );

  // clock / reset
  always #20 clock = ~clock;

  // memory model: byte at address a holds a[7:0]^A5, except the passthrough probe
  logic [7:0] mem [65536];
  assign bus_i = mem[bus_a];

  // reference CPU-cycle parity built from the divider definition
  int   div_m = 0;
  logic cyc_m = 1'b0;
  always @(posedge clock) begin
    if (!reset_n) begin
      div_m <= 0;
      cyc_m <= 1'b0;
    end else if (div_m == DIV - 1) begin
      div_m <= 0;
      cyc_m <= ~cyc_m;
    end else begin
      div_m <= div_m + 1;
    end
  end

  // bus monitor
  logic [7:0]  wr_q[$];
  logic [15:0] rd_q[$];
  int   zero_hit = 0;
  int   busy_clks = 0;
  int   ce_in_busy = 0;
  logic prev_w = 1'b0;
  logic prev_r = 1'b0;
  always @(negedge clock) begin
    if (bus_w && bus_a == 16'h2004 && !prev_w) wr_q.push_back(bus_o);
    if (dma_busy && bus_r && !prev_r) rd_q.push_back(bus_a);
    if (dma_busy && bus_a == 16'h0000 && (bus_r || bus_w)) zero_hit++;
    if (dma_busy) busy_clks++;
    if (dma_busy && cpu_ce) ce_in_busy++;
    prev_w = bus_w && bus_a == 16'h2004;
    prev_r = bus_r;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for a tick whose parity is want, then places the $4014 write before the next tick,
  // so the HALT tick sees cyc==want.
  task automatic trigger_dma(input logic [7:0] page, input logic want);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(cpu_ce && cyc_m == want) && n < 200);
    check("align_wait", 32'(n < 200), 32'd1);
    @(posedge clock);
    #1;
    cpu_a = 16'h4014;
    cpu_d = page;
    cpu_w = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!cpu_ce && n < 100);
    check("trigger_wait", 32'(n < 100), 32'd1);
    @(posedge clock);
    #1;
    cpu_w = 1'b0;
    cpu_a = 16'h0000;
    cpu_d = 8'h00;
  endtask

  task automatic run_dma(input string tag, input logic [7:0] page, input logic want);
    int wb, rb, zb, bb, cb, n, bad;
    wb = wr_q.size(); rb = rd_q.size();
    zb = zero_hit; bb = busy_clks; cb = ce_in_busy;
    trigger_dma(page, want);
    n = 0;
    while (dma_busy && n < 600 * DIV) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, 32'(dma_busy), 32'd0);
    check({tag, "_stall_clks"}, 32'(busy_clks - bb), 32'((want ? 514 : 513) * DIV));
    check({tag, "_ce_in_busy"}, 32'(ce_in_busy - cb), 32'd0);
    check({tag, "_wr_cnt"}, 32'(wr_q.size() - wb), 32'd256);
    check({tag, "_rd_cnt"}, 32'(rd_q.size() - rb), 32'd256);
    if (wr_q.size() - wb == 256 && rd_q.size() - rb == 256) begin
      bad = 0;
      for (int k = 0; k < 256; k++) begin
        if (wr_q[wb + k] !== (8'(k) ^ 8'hA5)) bad++;
        if (rd_q[rb + k] !== {page, 8'(k)}) bad++;
      end
      check({tag, "_seq_bad"}, 32'(bad), 32'd0);
      check({tag, "_wr_last"}, 32'(wr_q[wb + 255]), 32'h5A);
      check({tag, "_rd_first"}, 32'(rd_q[rb]), {16'h0, page, 8'h00});
      check({tag, "_rd_last"}, 32'(rd_q[rb + 255]), {16'h0, page, 8'hFF});
    end
    check({tag, "_zero_hit"}, 32'(zero_hit - zb), 32'd0);
  endtask

  initial begin
    int n, last, wb;
    for (int a = 0; a < 65536; a++) mem[a] = a[7:0] ^ 8'hA5;
    mem[16'h8000] = 8'h5A;
    reset_n = 1'b0;
    cpu_a = 16'h1234; cpu_d = 8'h00; cpu_r = 1'b0; cpu_w = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_bus_a", 32'(bus_a), 32'h1234);

    // divider: ce is high for the 14th edge after release, then every 14 edges
    @(negedge clock);
    reset_n = 1'b1;
    n = 0; last = 0;
    for (int p = 0; p < 3; p++) begin
      do begin
        @(posedge clock);
        n++;
        #1;
      end while (!cpu_ce && n < 100);
      check($sformatf("ce_edge%0d", p), 32'(n + 1), 32'(14 * (p + 1)));
      @(posedge clock);
      n++;
      #1;
      check($sformatf("ce_width%0d", p), 32'(cpu_ce), 32'd0);
    end

    // passthrough
    @(negedge clock);
    cpu_a = 16'h8000; cpu_r = 1'b1;
    #1;
    check("pt_rd_a", 32'(bus_a), 32'h8000);
    check("pt_rd_r", 32'(bus_r), 32'd1);
    check("pt_rd_i", 32'(cpu_i), 32'h5A);
    cpu_r = 1'b0; cpu_a = 16'h0300; cpu_d = 8'h77; cpu_w = 1'b1;
    #1;
    check("pt_wr_w", 32'(bus_w), 32'd1);
    check("pt_wr_o", 32'(bus_o), 32'h77);
    check("pt_wr_a", 32'(bus_a), 32'h0300);
    cpu_w = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00;

    run_dma("even", 8'h02, 1'b0);
    run_dma("odd", 8'h02, 1'b1);

    // reset after the 100th OAM write
    wb = wr_q.size();
    trigger_dma(8'h03, 1'b0);
    n = 0;
    while (wr_q.size() - wb < 100 && n < 300 * DIV) begin
      @(negedge clock);
      n++;
    end
    check("mid_reach100", 32'(wr_q.size() - wb), 32'd100);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("mid_busy", 32'(dma_busy), 32'd0);
    check("mid_bus_w", 32'(bus_w), 32'd0);
    check("mid_ce", 32'(cpu_ce), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (400 * DIV) @(negedge clock);
    check("mid_no_more_wr", 32'(wr_q.size() - wb), 32'd100);
    check("mid_idle", 32'(dma_busy), 32'd0);

    run_dma("pageff", 8'hFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
